// File: rtl/skinny_sbox_layer_ctrl.sv
// skinny_sbox_layer_ctrl
//   Streams the 16 nibbles of a masked 64-bit Skinny state through one shared,
//   fully pipelined masked 4-bit S-box, then reassembles the substituted state.
//   Also asks the PRNG for fresh randomness while the S-box pipeline may hold
//   live shares, and flags an underrun.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         request one S-box layer (sampled only in IDLE)
//   state_in      shared state, share j = [64j+63:64j], nibble k = [4k+3:4k]
//   state_out     substituted shared state, same layout, valid on done
//   busy          high while feeding or draining the S-box pipeline
//   done          one-cycle pulse when state_out is complete
//   err           sticky randomness-underrun flag for the current/last run
//   fresh_valid   PRNG output valid
//   fresh_req     PRNG advance request (S-box consumes randomness every cycle)
//   sbox_in       shared nibble to the S-box, share j = [4j+3:4j]
//   sbox_out      shared nibble from the S-box, same layout
module skinny_sbox_layer_ctrl #(
   parameter int SECURITY_ORDER = 2,
   parameter int SBOX_LATENCY   = 9,
   parameter int NIBBLES        = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [64*(SECURITY_ORDER+1)-1:0] state_in,
   output logic [64*(SECURITY_ORDER+1)-1:0] state_out,
   output logic                          busy,
   output logic                          done,
   output logic                          err,
   input  logic                          fresh_valid,
   output logic                          fresh_req,
   output logic [4*(SECURITY_ORDER+1)-1:0]  sbox_in,
   input  logic [4*(SECURITY_ORDER+1)-1:0]  sbox_out
);

   localparam int SHARES = SECURITY_ORDER + 1;
   localparam int CW     = $clog2(NIBBLES);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t                   state_reg;
   logic [CW-1:0]            feed_cnt_reg;
   logic [CW-1:0]            cap_cnt_reg;
   logic [SBOX_LATENCY-1:0]  vsr_reg;
   logic                     busy_reg;
   logic                     done_reg;
   logic                     err_reg;
   logic [4*SHARES-1:0]      sbox_in_reg;
   logic [64*SHARES-1:0]     in_reg;
   logic [64*SHARES-1:0]     state_out_reg;

   logic [CW-1:0]            sel_idx;
   logic [4*SHARES-1:0]      nib_first;
   logic [4*SHARES-1:0]      nib_next;

   assign sel_idx = feed_cnt_reg + CW'(1);

   // Nibble selection is done per share on its own slice; shares never meet.
   for (genvar gi = 0; gi < SHARES; gi++) begin : g_share_sel
      assign nib_first[4*gi +: 4] = state_in[64*gi +: 4];
      assign nib_next[4*gi +: 4]  = in_reg[64*gi + {sel_idx, 2'b00} +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         feed_cnt_reg  <= '0;
         cap_cnt_reg   <= '0;
         vsr_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
         sbox_in_reg   <= '0;
         in_reg        <= '0;
         state_out_reg <= '0;
      end else begin
         // A 1 enters at the end of each FEED cycle; the tail lines up with
         // the matching sbox_out exactly SBOX_LATENCY cycles later.
         vsr_reg  <= {vsr_reg[SBOX_LATENCY-2:0], state_reg == FEED};
         done_reg <= 1'b0;

         // fresh_req mirrors busy_reg, so this is "requested but not supplied".
         if (busy_reg && !fresh_valid) begin
            err_reg <= 1'b1;
         end

         if (vsr_reg[SBOX_LATENCY-1]) begin
            for (int j = 0; j < SHARES; j++) begin
               state_out_reg[64*j + {cap_cnt_reg, 2'b00} +: 4] <= sbox_out[4*j +: 4];
            end
            cap_cnt_reg <= cap_cnt_reg + CW'(1);
         end

         case (state_reg)
            IDLE: begin
               if (start && fresh_valid) begin
                  in_reg       <= state_in;
                  err_reg      <= 1'b0;
                  cap_cnt_reg  <= '0;
                  feed_cnt_reg <= '0;
                  sbox_in_reg  <= nib_first;
                  busy_reg     <= 1'b1;
                  state_reg    <= FEED;
               end
            end
            FEED: begin
               if (feed_cnt_reg == CW'(NIBBLES-1)) begin
                  sbox_in_reg <= '0;
                  state_reg   <= DRAIN;
               end else begin
                  feed_cnt_reg <= sel_idx;
                  sbox_in_reg  <= nib_next;
               end
            end
            DRAIN: begin
               if (vsr_reg[SBOX_LATENCY-1] && cap_cnt_reg == CW'(NIBBLES-1)) begin
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign state_out = state_out_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign fresh_req = busy_reg;
   assign sbox_in   = sbox_in_reg;

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// tb_skinny_sbox_layer_ctrl
//   Directed bench for skinny_sbox_layer_ctrl at default parameters (d=2,
//   latency 9, 16 nibbles). A behavioural masked S-box with 9-cycle latency
//   returns share0 = S(x0^x1^x2)^x1^x2, share1 = x1, share2 = x2.
module tb_skinny_sbox_layer_ctrl;

   localparam int LAT = 9;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [191:0] state_in;
   logic [191:0] state_out;
   logic         busy;
   logic         done;
   logic         err;
   logic         fresh_valid;
   logic         fresh_req;
   logic [11:0]  sbox_in;
   logic [11:0]  sbox_out;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   skinny_sbox_layer_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .state_in    (state_in),
      .state_out   (state_out),
      .busy        (busy),
      .done        (done),
      .err         (err),
      .fresh_valid (fresh_valid),
      .fresh_req   (fresh_req),
      .sbox_in     (sbox_in),
      .sbox_out    (sbox_out)
   );

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC;  4'h1: return 4'h6;  4'h2: return 4'h9;  4'h3: return 4'h0;
         4'h4: return 4'h1;  4'h5: return 4'hA;  4'h6: return 4'h2;  4'h7: return 4'hB;
         4'h8: return 4'h3;  4'h9: return 4'h8;  4'hA: return 4'h5;  4'hB: return 4'hD;
         4'hC: return 4'h4;  4'hD: return 4'hE;  4'hE: return 4'h7;  default: return 4'hF;
      endcase
   endfunction

   function automatic logic [11:0] masked_sbox(input logic [11:0] x);
      logic [3:0] y;
      y = sbox4(x[3:0] ^ x[7:4] ^ x[11:8]);
      return {x[11:8], x[7:4], y ^ x[7:4] ^ x[11:8]};
   endfunction

   logic [11:0] pipe [LAT];
   always @(posedge clk) begin
      pipe[0] <= masked_sbox(sbox_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign sbox_out = pipe[LAT-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " busy"}, busy, 1'b0);
      chk({tag, " done"}, done, 1'b0);
      chk({tag, " fresh_req"}, fresh_req, 1'b0);
      chk({tag, " sbox_in"}, sbox_in, 12'h0);
   endtask

   // Start in the current cycle (T) and follow the run cycle by cycle up to
   // the DONE cycle T+26, or until a reset injected in cycle T+rst_cyc.
   task automatic run_layer(input logic [191:0] st, input int drop_cyc,
                            input int rst_cyc, input bit hold_start);
      logic [11:0] exp_sb;
      state_in    = st;
      fresh_valid = 1'b1;
      start       = 1'b1;
      for (int c = 1; c <= 26; c++) begin
         tick();
         if (!hold_start) start = 1'b0;
         state_in = ~st;
         exp_sb = '0;
         if (c <= 16) begin
            for (int j = 0; j < 3; j++) exp_sb[4*j +: 4] = st[64*j + 4*(c-1) +: 4];
         end
         chk($sformatf("sbox_in c%0d", c), sbox_in, exp_sb);
         chk($sformatf("busy c%0d", c), busy, c <= 25);
         chk($sformatf("fresh_req c%0d", c), fresh_req, c <= 25);
         chk($sformatf("done c%0d", c), done, c == 26);
         chk($sformatf("err c%0d", c), err, drop_cyc > 0 && c > drop_cyc);
         fresh_valid = (c == drop_cyc) ? 1'b0 : 1'b1;
         if (c == rst_cyc) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk_idle("mid-reset");
            chk("mid-reset err", err, 1'b0);
            chk("mid-reset state_out", state_out, 192'h0);
            return;
         end
      end
   endtask

   logic [63:0]  plain, subst, s1, s2;
   logic [191:0] st_u, st_m, exp_u;

   initial begin
      plain = 64'h0123456789ABCDEF;
      subst = 64'hC6901A2B385D4E7F;
      s1    = 64'h5A5A1234DEADBEEF;
      s2    = 64'h0F1E2D3C4B5A6978;
      st_u  = {128'h0, plain};
      exp_u = {128'h0, subst};
      st_m  = {s2, s1, plain ^ s1 ^ s2};

      // Reset and idle
      rst = 1'b1; start = 1'b0; fresh_valid = 1'b0; state_in = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("reset%0d", i));
         chk("reset err", err, 1'b0);
         chk("reset state_out", state_out, 192'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle($sformatf("idle%0d", i));
         chk("idle err", err, 1'b0);
         chk("idle state_out", state_out, 192'h0);
      end

      // Unmasked vector
      run_layer(st_u, 0, 0, 1'b0);
      chk("unmasked state_out", state_out, exp_u);
      tick();
      chk_idle("after unmasked");
      chk("unmasked held", state_out, exp_u);

      // Masked vector
      run_layer(st_m, 0, 0, 1'b0);
      chk("masked xor", state_out[63:0] ^ state_out[127:64] ^ state_out[191:128], subst);
      chk("masked share1", state_out[127:64], s1);
      chk("masked share2", state_out[191:128], s2);
      tick();

      // Randomness underrun in cycle T+10
      run_layer(st_u, 10, 0, 1'b0);
      chk("underrun state_out", state_out, exp_u);
      tick();
      chk("underrun err sticky", err, 1'b1);
      tick();
      chk("underrun err sticky2", err, 1'b1);

      // start held through the whole run including DONE; next run clears err
      run_layer(st_m, 0, 0, 1'b1);
      chk("held xor", state_out[63:0] ^ state_out[127:64] ^ state_out[191:128], subst);
      tick();
      chk_idle("start in DONE ignored");
      start = 1'b0;
      tick();
      chk_idle("after held run");

      // start without fresh randomness in IDLE
      start = 1'b1; fresh_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle($sformatf("no fresh%0d", i));
         chk("no fresh err", err, 1'b0);
         chk("no fresh state_out", state_out[127:64], s1);
      end
      start = 1'b0; fresh_valid = 1'b1;
      tick();
      chk_idle("no fresh release");

      // Reset in cycle T+12, then a clean run
      run_layer(st_m, 0, 12, 1'b0);
      tick();
      chk_idle("post-reset idle");
      run_layer(st_u, 0, 0, 1'b0);
      chk("post-reset state_out", state_out, exp_u);
      tick();
      chk_idle("final idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
